// File: rtl/result_writeback_unit.sv
// Write-back stage: queues up to two ReLU result batches and drains each one as a
// series of single-port memory writes, lowest active lane first.
module result_writeback_unit #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int NUM_UNITS    = 2,
    localparam int ADDR_WIDTH  = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 result_valid,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] result_data,
    input  logic [NUM_UNITS-1:0]                 active_units,
    input  logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0] dst_addr,
    output logic                                 result_ready,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                mem_wdata,
    input  logic                                 mem_ready,
    output logic                                 wb_done,
    output logic                                 busy,
    output logic                                 overflow
);

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t state, state_next;

    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] fifo_data [2];
    logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0] fifo_addr [2];
    logic [NUM_UNITS-1:0]                 fifo_mask [2];
    logic                                 wr_ptr, rd_ptr;
    logic [1:0]                           count;

    logic [IDX_W-1:0] idx;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] head_data;
    logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0] head_addr;
    logic [NUM_UNITS-1:0]                 head_mask;

    logic             first_found, next_found;
    logic [IDX_W-1:0] first_lane, next_lane, load_lane;
    logic             push, pop, load, we_next, done_next;

    // Readiness comes only from the registered count, so a pop never frees a slot early.
    assign result_ready = reset && (count != 2'd2);
    assign push         = result_valid && result_ready;
    assign busy         = (count != 2'd0) || (state != IDLE);

    assign head_data = fifo_data[rd_ptr];
    assign head_addr = fifo_addr[rd_ptr];
    assign head_mask = fifo_mask[rd_ptr];

    // Lowest set lane overall, and lowest set lane strictly above the one in flight.
    always_comb begin
        first_found = 1'b0;
        first_lane  = '0;
        next_found  = 1'b0;
        next_lane   = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (head_mask[i]) begin
                first_found = 1'b1;
                first_lane  = IDX_W'(i);
            end
            if (head_mask[i] && (IDX_W'(i) > idx)) begin
                next_found = 1'b1;
                next_lane  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        load_lane  = first_lane;
        we_next    = mem_we;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    if (first_found) begin
                        load       = 1'b1;
                        we_next    = 1'b1;
                        state_next = WRITE;
                    end else begin
                        pop       = 1'b1;
                        done_next = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    if (next_found) begin
                        load      = 1'b1;
                        load_lane = next_lane;
                    end else begin
                        we_next    = 1'b0;
                        pop        = 1'b1;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_done   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            mem_we  <= we_next;
            wb_done <= done_next;
            if (load) begin
                idx       <= load_lane;
                mem_addr  <= head_addr[load_lane];
                mem_wdata <= head_data[load_lane];
            end
            if (push) begin
                fifo_data[wr_ptr] <= result_data;
                fifo_addr[wr_ptr] <= dst_addr;
                fifo_mask[wr_ptr] <= active_units;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (result_valid && !result_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_writeback_unit.sv
// Bench for result_writeback_unit: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model built from batch and lane-write queues.
module tb_result_writeback_unit;

    localparam int DW = 16;
    localparam int NU = 2;
    localparam int AW = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 result_valid;
    logic [NU-1:0][DW-1:0] result_data;
    logic [NU-1:0]         active_units;
    logic [NU-1:0][AW-1:0] dst_addr;
    logic                 result_ready;
    logic                 mem_we;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_ready;
    logic                 wb_done;
    logic                 busy;
    logic                 overflow;

    result_writeback_unit dut (
        .clk          (clk),
        .reset        (reset),
        .result_valid (result_valid),
        .result_data  (result_data),
        .active_units (active_units),
        .dst_addr     (dst_addr),
        .result_ready (result_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .wb_done      (wb_done),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NU-1:0]         mask;
        logic [NU-1:0][DW-1:0] data;
        logic [NU-1:0][AW-1:0] addr;
    } batch_t;

    // Reference model: queued batches (head = the one being drained) and the
    // remaining lane writes of the head batch in ascending lane order.
    batch_t q[$];
    int     lanes[$];
    bit     m_active;
    bit     m_done;
    bit     m_ovf;
    bit     m_was_reset;
    bit     checking_on;

    int checks;
    int failures;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        if (checking_on) begin
            checkOutput("result_ready", 32'(result_ready), 32'(reset && (q.size() < 2)));
            checkOutput("mem_we", 32'(mem_we), 32'(m_active));
            checkOutput("wb_done", 32'(wb_done), 32'(m_done));
            checkOutput("busy", 32'(busy), 32'(q.size() != 0));
            checkOutput("overflow", 32'(overflow), 32'(m_ovf));
            if (m_active) begin
                checkOutput("mem_addr", 32'(mem_addr), 32'(q[0].addr[lanes[0]]));
                checkOutput("mem_wdata", 32'(mem_wdata), 32'(q[0].data[lanes[0]]));
            end else if (m_was_reset) begin
                checkOutput("mem_addr_rst", 32'(mem_addr), 32'd0);
                checkOutput("mem_wdata_rst", 32'(mem_wdata), 32'd0);
            end
        end
    endtask

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        batch_t b;
        bit     ready;
        if (!reset) begin
            q.delete();
            lanes.delete();
            m_active    = 1'b0;
            m_done      = 1'b0;
            m_ovf       = 1'b0;
            m_was_reset = 1'b1;
            return;
        end
        m_was_reset = 1'b0;
        ready       = (q.size() < 2);
        m_done      = 1'b0;
        if (m_active) begin
            if (mem_ready) begin
                void'(lanes.pop_front());
                if (lanes.size() == 0) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    void'(q.pop_front());
                end
            end
        end else if (q.size() != 0) begin
            for (int i = 0; i < NU; i++) begin
                if (q[0].mask[i]) lanes.push_back(i);
            end
            if (lanes.size() == 0) begin
                m_done = 1'b1;
                void'(q.pop_front());
            end else begin
                m_active = 1'b1;
            end
        end
        if (result_valid) begin
            if (ready) begin
                b.mask = active_units;
                b.data = result_data;
                b.addr = dst_addr;
                q.push_back(b);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic mr,
                                 input logic [NU-1:0] mask,
                                 input logic [NU-1:0][DW-1:0] data,
                                 input logic [NU-1:0][AW-1:0] addr);
        @(negedge clk);
        checkAll();
        checking_on  = 1'b1;
        reset        = rst;
        result_valid = v;
        mem_ready    = mr;
        active_units = mask;
        result_data  = data;
        dst_addr     = addr;
        modelStep();
    endtask

    task automatic idleCycles(input int n, input logic mr);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, mr, '0, '0, '0);
    endtask

    logic [NU-1:0][DW-1:0] r_data;
    logic [NU-1:0][AW-1:0] r_addr;
    logic [NU-1:0]         r_mask;

    initial begin
        checks       = 0;
        failures     = 0;
        checking_on  = 1'b0;
        m_active     = 1'b0;
        m_done       = 1'b0;
        m_ovf        = 1'b0;
        m_was_reset  = 1'b0;
        reset        = 1'b0;
        result_valid = 1'b0;
        mem_ready    = 1'b0;
        active_units = '0;
        result_data  = '0;
        dst_addr     = '0;

        $display("[TB] reset held with result_valid high");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, {16'h1111, 16'h2222}, {6'd1, 6'd2});
        idleCycles(2, 1'b1);

        $display("[TB] full batch");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, {16'h0007, 16'h0003}, {6'd40, 6'd10});
        idleCycles(5, 1'b1);

        $display("[TB] sparse and empty masks");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, {16'h0007, 16'h0003}, {6'd40, 6'd10});
        idleCycles(4, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, {16'h0007, 16'h0003}, {6'd40, 6'd10});
        idleCycles(4, 1'b1);

        $display("[TB] backpressure on first write");
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, {16'hbeef, 16'hcafe}, {6'd63, 6'd0});
        idleCycles(4, 1'b0);
        idleCycles(5, 1'b1);

        $display("[TB] overflow with stalled memory");
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, {16'h0000, 16'h00a1}, {6'd0, 6'd5});
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, {16'h00b2, 16'h00b1}, {6'd7, 6'd6});
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, {16'h00c2, 16'h00c1}, {6'd9, 6'd8});
        idleCycles(3, 1'b0);
        idleCycles(8, 1'b1);

        $display("[TB] reset mid-write with a batch queued");
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, {16'h0d02, 16'h0d01}, {6'd21, 6'd20});
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b11, {16'h0e02, 16'h0e01}, {6'd23, 6'd22});
        idleCycles(2, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b11, {16'h0f02, 16'h0f01}, {6'd33, 6'd33});
        idleCycles(5, 1'b1);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            for (int l = 0; l < NU; l++) begin
                r_data[l] = DW'($urandom);
                r_addr[l] = ($urandom_range(0, 3) == 0) ? AW'(3) : AW'($urandom);
            end
            r_mask = NU'($urandom);
            applyStimulus(($urandom_range(0, 299) != 0),
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 9) < 7),
                          r_mask, r_data, r_addr);
        end
        idleCycles(10, 1'b1);

        @(negedge clk);
        checkAll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
